// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped data cache: FSM states, address
// field layout and block/word geometry.
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2,
        UPDATE    = 2'd3
    } state_t;

    localparam int ADDR_BITS       = 32;
    localparam int BLOCK_ADDR_BITS = 28;
    localparam int BLOCK_BITS      = 128;
    localparam int WORD_BITS       = 32;
    localparam int BYTE_BITS       = 8;
    localparam int BYTES_PER_WORD  = WORD_BITS / BYTE_BITS;
    localparam int WORDS_PER_BLOCK = BLOCK_BITS / WORD_BITS;
    localparam int BYTES_PER_BLOCK = BLOCK_BITS / BYTE_BITS;
    localparam int WORD_LSB        = 2;
    localparam int WORD_SEL_BITS   = 2;
    localparam int INDEX_LSB       = 4;

endpackage

// File: rtl/dcache_line_array.sv
// Tag/valid/dirty/data storage for the cache lines: asynchronous read,
// byte-enabled word write and full-line fill on the rising clock edge.
module dcache_line_array
    import dcache_pkg::*;
#(
    parameter int INDEX_BITS = 3,
    parameter int TAG_BITS   = BLOCK_ADDR_BITS - INDEX_BITS
) (
    input  logic                      clk,
    input  logic                      srst,
    input  logic [INDEX_BITS-1:0]     rd_index,
    output logic                      rd_valid,
    output logic                      rd_dirty,
    output logic [TAG_BITS-1:0]       rd_tag,
    output logic [BLOCK_BITS-1:0]     rd_data,
    input  logic                      wr_en,
    input  logic [INDEX_BITS-1:0]     wr_index,
    input  logic [WORD_SEL_BITS-1:0]  wr_word,
    input  logic [BYTES_PER_WORD-1:0] wr_byteen,
    input  logic [WORD_BITS-1:0]      wr_data,
    input  logic                      fill_en,
    input  logic [INDEX_BITS-1:0]     fill_index,
    input  logic [TAG_BITS-1:0]       fill_tag,
    input  logic [BLOCK_BITS-1:0]     fill_data
);

    localparam int LINES = 1 << INDEX_BITS;

    logic [LINES-1:0]      valid_reg;
    logic [LINES-1:0]      dirty_reg;
    logic [TAG_BITS-1:0]   tag_mem  [LINES];
    logic [BLOCK_BITS-1:0] data_mem [LINES];

    logic [BLOCK_BITS-1:0] wr_mask;
    logic [BLOCK_BITS-1:0] wr_block;

    // Spread the word store across the block: each byte lane is enabled only
    // when it belongs to the addressed word and its byte enable is set.
    genvar gi;
    generate
        for (gi = 0; gi < BYTES_PER_BLOCK; gi++) begin : g_lane
            assign wr_mask[gi*BYTE_BITS +: BYTE_BITS] =
                {BYTE_BITS{(wr_word == WORD_SEL_BITS'(gi / BYTES_PER_WORD)) &&
                           wr_byteen[gi % BYTES_PER_WORD]}};
            assign wr_block[gi*BYTE_BITS +: BYTE_BITS] =
                wr_data[(gi % BYTES_PER_WORD)*BYTE_BITS +: BYTE_BITS];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (srst) begin
            valid_reg <= '0;
            dirty_reg <= '0;
        end else if (fill_en) begin
            valid_reg[fill_index] <= 1'b1;
            dirty_reg[fill_index] <= 1'b0;
        end else if (wr_en) begin
            dirty_reg[wr_index] <= 1'b1;
        end
    end

    // Line contents are not reset; an invalid line is never reported as a hit.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_mem[fill_index]  <= fill_tag;
            data_mem[fill_index] <= fill_data;
        end else if (wr_en) begin
            data_mem[wr_index] <= (data_mem[wr_index] & ~wr_mask) | (wr_block & wr_mask);
        end
    end

    assign rd_valid = valid_reg[rd_index];
    assign rd_dirty = dirty_reg[rd_index];
    assign rd_tag   = tag_mem[rd_index];
    assign rd_data  = data_mem[rd_index];

endmodule

// File: rtl/data_cache_controller.sv
// Direct-mapped, write-back, write-allocate data cache controller with a
// blocking CPU interface and a 128-bit block memory interface.
module data_cache_controller
    import dcache_pkg::*;
#(
    parameter int INDEX_BITS = 3
) (
    input  logic                       CLOCK,
    input  logic                       RESET,
    input  logic                       CPU_READ,
    input  logic                       CPU_WRITE,
    input  logic [ADDR_BITS-1:0]       CPU_ADDRESS,
    input  logic [BYTES_PER_WORD-1:0]  CPU_BYTEEN,
    input  logic [WORD_BITS-1:0]       CPU_WRITEDATA,
    output logic [WORD_BITS-1:0]       CPU_READDATA,
    output logic                       CPU_BUSYWAIT,
    output logic                       MEM_READ,
    output logic                       MEM_WRITE,
    output logic [BLOCK_ADDR_BITS-1:0] MEM_ADDRESS,
    output logic [BLOCK_BITS-1:0]      MEM_WRITEDATA,
    input  logic [BLOCK_BITS-1:0]      MEM_READDATA,
    input  logic                       MEM_BUSYWAIT
);

    localparam int TAG_BITS = BLOCK_ADDR_BITS - INDEX_BITS;

    state_t                     state_reg;
    logic                       first_reg;
    logic [TAG_BITS-1:0]        req_tag_reg;
    logic [INDEX_BITS-1:0]      req_index_reg;
    logic [BLOCK_BITS-1:0]      fill_data_reg;

    logic [TAG_BITS-1:0]        addr_tag;
    logic [INDEX_BITS-1:0]      addr_index;
    logic [WORD_SEL_BITS-1:0]   addr_word;
    logic                       request;
    logic                       hit;
    logic                       wr_en;
    logic                       fill_en;
    logic                       line_valid;
    logic                       line_dirty;
    logic [TAG_BITS-1:0]        line_tag;
    logic [BLOCK_BITS-1:0]      line_data;
    logic [WORDS_PER_BLOCK-1:0][WORD_BITS-1:0] line_words;
    logic                       unused_addr_bits;

    assign addr_tag         = CPU_ADDRESS[ADDR_BITS-1 -: TAG_BITS];
    assign addr_index       = CPU_ADDRESS[INDEX_LSB +: INDEX_BITS];
    assign addr_word        = CPU_ADDRESS[WORD_LSB +: WORD_SEL_BITS];
    assign unused_addr_bits = ^CPU_ADDRESS[WORD_LSB-1:0];

    // Read and write together is treated as no request at all.
    assign request = CPU_READ ^ CPU_WRITE;
    assign hit     = line_valid && (line_tag == addr_tag);

    assign CPU_BUSYWAIT = !RESET && request && !((state_reg == IDLE) && hit);
    assign line_words   = line_data;
    assign CPU_READDATA = RESET ? '0 : line_words[addr_word];

    assign wr_en   = !RESET && (state_reg == IDLE) && CPU_WRITE && !CPU_READ && hit;
    assign fill_en = !RESET && (state_reg == UPDATE);

    dcache_line_array #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TAG_BITS)
    ) u_lines (
        .clk        (CLOCK),
        .srst       (RESET),
        .rd_index   (addr_index),
        .rd_valid   (line_valid),
        .rd_dirty   (line_dirty),
        .rd_tag     (line_tag),
        .rd_data    (line_data),
        .wr_en      (wr_en),
        .wr_index   (addr_index),
        .wr_word    (addr_word),
        .wr_byteen  (CPU_BYTEEN),
        .wr_data    (CPU_WRITEDATA),
        .fill_en    (fill_en),
        .fill_index (req_index_reg),
        .fill_tag   (req_tag_reg),
        .fill_data  (fill_data_reg)
    );

    // first_reg marks the opening cycle of a transfer, during which the
    // memory's busy flag is not yet trustworthy and is ignored.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_reg     <= IDLE;
            first_reg     <= 1'b0;
            req_tag_reg   <= '0;
            req_index_reg <= '0;
            fill_data_reg <= '0;
            MEM_READ      <= 1'b0;
            MEM_WRITE     <= 1'b0;
            MEM_ADDRESS   <= '0;
            MEM_WRITEDATA <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (request && !hit) begin
                        req_tag_reg   <= addr_tag;
                        req_index_reg <= addr_index;
                        first_reg     <= 1'b1;
                        if (line_valid && line_dirty) begin
                            state_reg     <= WRITEBACK;
                            MEM_WRITE     <= 1'b1;
                            MEM_ADDRESS   <= {line_tag, addr_index};
                            MEM_WRITEDATA <= line_data;
                        end else begin
                            state_reg   <= ALLOCATE;
                            MEM_READ    <= 1'b1;
                            MEM_ADDRESS <= {addr_tag, addr_index};
                        end
                    end
                end
                WRITEBACK: begin
                    first_reg <= 1'b0;
                    if (!first_reg && !MEM_BUSYWAIT) begin
                        state_reg   <= ALLOCATE;
                        first_reg   <= 1'b1;
                        MEM_WRITE   <= 1'b0;
                        MEM_READ    <= 1'b1;
                        MEM_ADDRESS <= {req_tag_reg, req_index_reg};
                    end
                end
                ALLOCATE: begin
                    first_reg <= 1'b0;
                    if (!first_reg && !MEM_BUSYWAIT) begin
                        state_reg     <= UPDATE;
                        MEM_READ      <= 1'b0;
                        fill_data_reg <= MEM_READDATA;
                    end
                end
                UPDATE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_cache_controller.sv
// Randomised self-checking bench: architectural memory image plus a block
// residency map predict hits, evictions, transfer lengths and load data.
module tb_data_cache_controller;

    logic         CLOCK = 1'b0;
    logic         RESET = 1'b1;
    logic         CPU_READ = 1'b0;
    logic         CPU_WRITE = 1'b0;
    logic [31:0]  CPU_ADDRESS = '0;
    logic [3:0]   CPU_BYTEEN = '0;
    logic [31:0]  CPU_WRITEDATA = '0;
    logic [31:0]  CPU_READDATA;
    logic         CPU_BUSYWAIT;
    logic         MEM_READ;
    logic         MEM_WRITE;
    logic [27:0]  MEM_ADDRESS;
    logic [127:0] MEM_WRITEDATA;
    logic [127:0] MEM_READDATA = '0;
    logic         MEM_BUSYWAIT = 1'b0;

    data_cache_controller #(.INDEX_BITS(3)) dut (
        .CLOCK         (CLOCK),
        .RESET         (RESET),
        .CPU_READ      (CPU_READ),
        .CPU_WRITE     (CPU_WRITE),
        .CPU_ADDRESS   (CPU_ADDRESS),
        .CPU_BYTEEN    (CPU_BYTEEN),
        .CPU_WRITEDATA (CPU_WRITEDATA),
        .CPU_READDATA  (CPU_READDATA),
        .CPU_BUSYWAIT  (CPU_BUSYWAIT),
        .MEM_READ      (MEM_READ),
        .MEM_WRITE     (MEM_WRITE),
        .MEM_ADDRESS   (MEM_ADDRESS),
        .MEM_WRITEDATA (MEM_WRITEDATA),
        .MEM_READDATA  (MEM_READDATA),
        .MEM_BUSYWAIT  (MEM_BUSYWAIT)
    );

    always #5 CLOCK = ~CLOCK;

    int errors = 0;
    int checks = 0;

    logic [127:0] mem  [32];   // backing memory as seen by the bus
    logic [127:0] refm [32];   // architectural contents the CPU must observe
    logic [27:0]  res_blk [8];
    bit           res_v [8];
    bit           res_d [8];

    bit           skip_len = 1'b0;
    logic [27:0]  wb_addr, al_addr;
    logic [31:0]  last_rdata;
    bit           last_wr;

    task automatic chk(input bit ok, input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory responder: random busy latency per transfer, and a check that
    // each transfer lasts exactly max(1,lat)+1 cycles.
    logic [1:0] prev_kind = 2'b00;
    int cnt = 0;
    int lat = 0;
    always @(negedge CLOCK) begin
        logic [1:0] kind;
        kind = {MEM_READ, MEM_WRITE};
        if (kind != prev_kind) begin
            if (prev_kind != 2'b00 && !skip_len)
                chk(cnt == ((lat > 1 ? lat : 1) + 1), "xfer_len", 128'(cnt), 128'((lat > 1 ? lat : 1) + 1));
            cnt = 0;
            lat = $urandom_range(0, 3);
        end
        if (kind != 2'b00) begin
            if (MEM_WRITE) mem[MEM_ADDRESS[4:0]] = MEM_WRITEDATA;
            if (MEM_READ)  MEM_READDATA = mem[MEM_ADDRESS[4:0]];
            MEM_BUSYWAIT = (cnt < lat);
            cnt++;
        end else begin
            MEM_BUSYWAIT = 1'($urandom_range(0, 1));
        end
        prev_kind = kind;
    end

    // Every-cycle invariants.
    always @(negedge CLOCK) begin
        chk(!(MEM_READ && MEM_WRITE), "mem_exclusive", {MEM_READ, MEM_WRITE}, 2'b00);
        if (RESET) begin
            chk(CPU_BUSYWAIT == 1'b0, "busy_in_reset", CPU_BUSYWAIT, 1'b0);
            chk(CPU_READDATA == 32'h0, "rdata_in_reset", CPU_READDATA, 32'h0);
        end
    end

    task automatic access(input bit is_wr, input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wd);
        logic [27:0] blk;
        int idx, w, k, cycles;
        bit exp_miss, exp_wb, first, done, saw_wr, saw_rd;
        logic [27:0] old_blk;
        blk = addr[31:4];
        idx = int'(blk[2:0]);
        k = int'(blk[4:0]);
        w = int'(addr[3:2]);
        exp_miss = !(res_v[idx] && res_blk[idx] == blk);
        exp_wb = exp_miss && res_v[idx] && res_d[idx];
        old_blk = res_blk[idx];
        @(posedge CLOCK); #1;
        CPU_ADDRESS = addr; CPU_BYTEEN = be; CPU_WRITEDATA = wd;
        CPU_READ = !is_wr; CPU_WRITE = is_wr;
        first = 1; done = 0; saw_wr = 0; saw_rd = 0; cycles = 0;
        while (!done) begin
            @(negedge CLOCK);
            if (first) chk(CPU_BUSYWAIT == exp_miss, "miss_detect", CPU_BUSYWAIT, exp_miss);
            first = 0;
            if (MEM_WRITE) begin saw_wr = 1; wb_addr = MEM_ADDRESS; end
            if (MEM_READ)  begin saw_rd = 1; al_addr = MEM_ADDRESS; end
            if (!CPU_BUSYWAIT) begin
                done = 1;
                if (!is_wr) begin
                    last_rdata = CPU_READDATA;
                    chk(CPU_READDATA == refm[k][w*32 +: 32], "read_data", CPU_READDATA, refm[k][w*32 +: 32]);
                end
            end else if (++cycles > 100) begin
                chk(0, "timeout", 0, 1);
                done = 1;
            end
        end
        last_wr = saw_wr;
        chk(saw_wr == exp_wb, "writeback_pulse", saw_wr, exp_wb);
        if (exp_wb && saw_wr) chk(wb_addr == old_blk, "wb_addr", wb_addr, old_blk);
        chk(saw_rd == exp_miss, "alloc_pulse", saw_rd, exp_miss);
        if (exp_miss && saw_rd) chk(al_addr == blk, "alloc_addr", al_addr, blk);
        if (exp_miss) begin
            res_blk[idx] = blk; res_v[idx] = 1; res_d[idx] = 0;
        end
        if (is_wr) begin
            res_d[idx] = 1;
            for (int b = 0; b < 4; b++)
                if (be[b]) refm[k][w*32 + b*8 +: 8] = wd[b*8 +: 8];
        end
        @(posedge CLOCK); #1;
        CPU_READ = 0; CPU_WRITE = 0;
    endtask

    task automatic illegal_op(input logic [31:0] addr);
        @(posedge CLOCK); #1;
        CPU_ADDRESS = addr; CPU_WRITEDATA = $urandom; CPU_BYTEEN = 4'hF;
        CPU_READ = 1; CPU_WRITE = 1;
        for (int i = 0; i < 2; i++) begin
            @(negedge CLOCK);
            chk(CPU_BUSYWAIT == 1'b0, "illegal_busy", CPU_BUSYWAIT, 1'b0);
            chk(!MEM_READ && !MEM_WRITE, "illegal_mem", {MEM_READ, MEM_WRITE}, 2'b00);
        end
        @(posedge CLOCK); #1;
        CPU_READ = 0; CPU_WRITE = 0;
    endtask

    initial begin
        bit seen;
        for (int i = 0; i < 32; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
        mem[1] = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        for (int i = 0; i < 32; i++) refm[i] = mem[i];
        for (int i = 0; i < 8; i++) begin res_v[i] = 0; res_d[i] = 0; res_blk[i] = '0; end

        // Reset with a pending read: busy must stay low, memory side idle.
        CPU_READ = 1; CPU_ADDRESS = 32'h14;
        repeat (2) @(posedge CLOCK);
        @(negedge CLOCK);
        chk(MEM_READ == 0 && MEM_WRITE == 0, "reset_mem_req", {MEM_READ, MEM_WRITE}, 2'b00);
        chk(MEM_ADDRESS == 28'h0, "reset_mem_addr", MEM_ADDRESS, 28'h0);
        chk(MEM_WRITEDATA == 128'h0, "reset_mem_wdata", MEM_WRITEDATA, 128'h0);
        @(posedge CLOCK); #1;
        RESET = 0; CPU_READ = 0;

        // Cold read miss.
        access(0, 32'h14, 4'h0, 32'h0);
        chk(al_addr == 28'h1, "cold_alloc_addr", al_addr, 28'h1);
        chk(last_rdata == 32'h22222222, "cold_read", last_rdata, 32'h22222222);

        // Write hit on low half-word, then read back.
        access(1, 32'h10, 4'b0011, 32'hDEADBEEF);
        access(0, 32'h10, 4'h0, 32'h0);
        chk(last_rdata == 32'h1111BEEF, "write_hit_read", last_rdata, 32'h1111BEEF);

        // Dirty eviction.
        access(0, 32'h90, 4'h0, 32'h0);
        chk(wb_addr == 28'h1, "dirty_wb_addr", wb_addr, 28'h1);
        chk(al_addr == 28'h9, "dirty_alloc_addr", al_addr, 28'h9);

        illegal_op(32'h94);

        // Clean eviction back to block 1; written-back data must return.
        access(0, 32'h14, 4'h0, 32'h0);
        chk(last_wr == 0, "clean_evict_nowrite", last_wr, 0);
        access(0, 32'h10, 4'h0, 32'h0);
        chk(last_rdata == 32'h1111BEEF, "wb_roundtrip", last_rdata, 32'h1111BEEF);

        // Reset in the middle of an allocate.
        @(posedge CLOCK); #1;
        CPU_ADDRESS = 32'h94; CPU_READ = 1;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge CLOCK);
            if (MEM_READ) seen = 1;
        end
        chk(seen, "alloc_before_reset", seen, 1);
        skip_len = 1; RESET = 1;
        @(posedge CLOCK); #1;
        chk(MEM_READ == 0 && MEM_WRITE == 0, "reset_abandon", {MEM_READ, MEM_WRITE}, 2'b00);
        chk(CPU_BUSYWAIT == 0, "reset_busy_low", CPU_BUSYWAIT, 0);
        RESET = 0; CPU_READ = 0;
        for (int i = 0; i < 8; i++) begin res_v[i] = 0; res_d[i] = 0; end
        repeat (2) @(negedge CLOCK);
        skip_len = 0;
        access(0, 32'h14, 4'h0, 32'h0);
        chk(al_addr == 28'h1, "post_reset_miss_addr", al_addr, 28'h1);
        chk(last_rdata == 32'h22222222, "post_reset_read", last_rdata, 32'h22222222);

        // Random traffic over 4 tags x 8 indices.
        for (int n = 0; n < 400; n++) begin
            logic [31:0] a;
            a = {25'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'b00};
            case ($urandom_range(0, 9))
                0:       illegal_op(a);
                1, 2, 3, 4: access(1, a, 4'($urandom), $urandom);
                default: access(0, a, 4'h0, 32'h0);
            endcase
        end

        repeat (3) @(posedge CLOCK);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/data_cache_controller.md
DATA_CACHE_CONTROLLER -- requirements
Module: data_cache_controller

Interface
REQ-001 SHALL have parameter INDEX_BITS, default 3: line index width, 2**INDEX_BITS direct-mapped 128-bit lines.
REQ-002 SHALL derive TAG_BITS = 28 - INDEX_BITS.
REQ-003 SHALL have one clock and a synchronous, active-high reset:
- CLOCK  in  1  clock; all state changes on its rising edge.
- RESET  in  1  synchronous, active-high reset.
REQ-004 SHALL have these CPU-side ports:
- CPU_READ  in  1  load request, held until CPU_BUSYWAIT is low.
- CPU_WRITE  in  1  store request, held until CPU_BUSYWAIT is low.
- CPU_ADDRESS  in  32  byte address; [1:0] ignored, [3:2] word, [3+INDEX_BITS:4] index, [31:4+INDEX_BITS] tag.
- CPU_BYTEEN  in  4  store byte enables for word lanes 0..3.
- CPU_WRITEDATA  in  32  store data.
- CPU_READDATA  out  32  load data.
- CPU_BUSYWAIT  out  1  stall to the pipeline.
REQ-005 SHALL have these memory-side ports:
- MEM_READ  out  1  block read request.
- MEM_WRITE  out  1  block write request.
- MEM_ADDRESS  out  28  block address = byte address [31:4].
- MEM_WRITEDATA  out  128  block data.
- MEM_READDATA  in  128  block data.
- MEM_BUSYWAIT  in  1  memory busy.
REQ-006 SHALL pack byte b of a block at bits [8b+7:8b] and word w at [32w+31:32w].

Function
REQ-007 SHALL implement FSM states IDLE, WRITEBACK, ALLOCATE and UPDATE.
REQ-008 SHALL define a hit as valid[index] and tag[index] equal to the address tag.
REQ-009 SHALL treat CPU_READ and CPU_WRITE asserted together as no request: CPU_BUSYWAIT low, no state change.
REQ-010 SHALL derive CPU_BUSYWAIT combinationally:
- High when a request is present and not (state IDLE and hit).
- Low otherwise.
REQ-011 SHALL return CPU_READDATA combinationally from the selected word on a read hit, zero-latency.
- CPU_READDATA is otherwise don't-care, but SHALL be driven 0 during reset.
REQ-012 SHALL handle a write hit at the next rising edge: update only the enabled bytes of the word and set dirty[index].
REQ-013 SHALL, on a miss in IDLE, go to WRITEBACK if the line is valid and dirty, else go to ALLOCATE.
REQ-014 SHALL drive in WRITEBACK: MEM_WRITE=1, MEM_ADDRESS={stored tag, index}, MEM_WRITEDATA=line.
REQ-015 SHALL drive in ALLOCATE: MEM_READ=1, MEM_ADDRESS={request tag, index}.
REQ-016 SHALL ignore MEM_BUSYWAIT in the first cycle of WRITEBACK or ALLOCATE.
- The memory transfer completes at the first later rising edge with MEM_BUSYWAIT sampled low.
REQ-017 SHALL go WRITEBACK -> ALLOCATE and ALLOCATE -> UPDATE on transfer completion.
- MEM_READ and MEM_WRITE SHALL never be high together.
REQ-018 SHALL, in UPDATE (one cycle, memory outputs low):
- Write the latched MEM_READDATA block to the line.
- Set valid and the tag, clear dirty.
- Go to IDLE, where the pending request hits (write-allocate).
REQ-019 SHALL latch MEM_READDATA at ALLOCATE completion.
REQ-020 SHALL keep the miss request stable while CPU_BUSYWAIT is high; an address change mid-miss is illegal and unchecked.
REQ-021 SHALL take a miss to a different tag on a valid clean line directly to ALLOCATE, with no memory write.

Reset
REQ-022 SHALL, with RESET high at a rising edge:
- Set state to IDLE.
- Clear all valid and dirty bits.
- Set MEM_READ, MEM_WRITE and CPU_READDATA to 0.
- Set MEM_ADDRESS and MEM_WRITEDATA to 0.
REQ-023 SHALL abandon any memory transfer in progress on reset, with MEM_READ/MEM_WRITE low from that edge.
- Line data need not be cleared.
REQ-024 SHALL hold CPU_BUSYWAIT low while RESET is high.

Structure
REQ-025 SHALL define in the shared package dcache_pkg:
- The state enumeration.
- Address field widths and offsets.
- Block width 128 and word width 32.
REQ-026 SHALL keep the tag/valid/dirty/data arrays in the sub-module dcache_line_array:
- Asynchronous read.
- Synchronous byte-enabled word write.
- Synchronous full-line fill.
- FSM and handshake stay in the top module.

Verification
REQ-027 Read miss, cold: after reset, read 0x00000014 -> one-cycle guard, then ALLOCATE with MEM_ADDRESS=0x0000001 until MEM_BUSYWAIT is low, then UPDATE, then hit with CPU_READDATA = MEM_READDATA[63:32].
REQ-028 Write hit: write 0xDEADBEEF to 0x00000010 with CPU_BYTEEN=4'b0011 -> no stall, low half updated, dirty set, next read returns {old[31:16],16'hBEEF}.
REQ-029 Dirty eviction: dirty line at 0x00000010, then read 0x00000090 (same index 1) -> WRITEBACK MEM_ADDRESS=0x0000001, then ALLOCATE MEM_ADDRESS=0x0000009.
REQ-030 Clean eviction: clean line, conflicting read -> no MEM_WRITE pulse.
REQ-031 Reset mid-transfer: RESET during ALLOCATE -> MEM_READ low the next cycle, all lines invalid, read 0x00000014 misses again.
REQ-032 Illegal request: CPU_READ=CPU_WRITE=1 -> CPU_BUSYWAIT=0, no memory request, no array change.
